serial_alu: RTL and testbench
=============================

# serial_alu

Multi-cycle, slice-serial execution unit that consumes the 3-bit ALUControl code produced by the ALU control decoder. It executes the operation on two XLEN-bit operands, SLICE bits per cycle, for area-constrained builds of the RV32I core. Requests and results move over valid/ready handshakes. The unit returns the result word and a zero flag for branch resolution.

## Interface
- XLEN, 32, operand/result width
- SLICE, 4, bits processed per cycle; must divide XLEN; N = XLEN/SLICE cycles per operation
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- alu_ctrl  in  3  ALUControl code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT; 110/111 execute as ADD
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2/imm)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- in_ready = (state == IDLE) && !rst.
- IDLE: on in_valid && in_ready, latch the following, then go to RUN:
  - alu_ctrl, a into a_sh, b into b_sh
  - slice counter = 0
  - carry = 1 for SUB/SLT, 0 otherwise
  - zero accumulator = 0
- RUN: each cycle processes the low SLICE bits of a_sh and b_sh.
  - ADD: a + b + carry.
  - SUB/SLT: a + ~b + carry.
  - AND/OR/XOR: bitwise; carry unused.
  - Slice result enters the MSB end of the result shift register; a_sh and b_sh shift right by SLICE.
  - Carry-out is registered for the next slice.
  - The zero accumulator ORs in the slice result.
  - On the last slice (counter == N-1), go to DONE and set out_valid.
- SLT on last slice:
  - overflow = (a_msb != b_msb) && (sum_msb != a_msb)
  - less = sum_msb ^ overflow
  - result = {XLEN-1 zeros, less}
  - zero = !less
- Other ops: zero = !(accumulated OR of all slices).
- DONE: hold result, zero and out_valid until out_ready; on the out_valid && out_ready edge go to IDLE and clear out_valid. result and zero retain their last values.
- Inputs are ignored outside the accept edge. Changes to a, b or alu_ctrl during RUN/DONE have no effect.
- Arithmetic is modulo 2^XLEN; final carry-out is discarded.

## Timing
- Reset values: out_valid 0, result 0, zero 0, state IDLE, counter 0. in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Latency: accept edge E0; slices are processed at edges E1..EN. out_valid is high after EN, i.e. N cycles after acceptance (8 for defaults).
- Throughput: one operation per N+2 cycles minimum (accept, N slices, result handshake). No overlap: in_ready stays 0 in RUN and DONE.
- Backpressure: with out_ready low, DONE holds indefinitely and outputs stay stable.
- Reset mid-RUN or mid-DONE: the operation is abandoned, out_valid is 0 after the reset edge, and no result is emitted.
- rst has priority over every handshake in the same cycle.

## Structure
- Package alu_pkg holds:
  - ALUControl localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_XOR=3'b100, ALU_SLT=3'b101
  - FSM state encoding (IDLE/RUN/DONE)
- The ALU control decoder imports the same constants.
- Sub-module serial_alu_slice: combinational SLICE-bit datapath with inputs op, a, b, cin and outputs res, cout.
- serial_alu instantiates serial_alu_slice once and owns the FSM, shift registers, counter, carry and flags.

## Test plan
- ADD a=0x7FFFFFFF, b=0x00000001 → result 0x80000000, zero 0, out_valid exactly 8 cycles after accept.
- SUB a=5, b=5 → result 0, zero 1; SUB a=0, b=1 → 0xFFFFFFFF, zero 0.
- SLT a=0xFFFFFFFF, b=1 → result 1, zero 0; SLT a=0x7FFFFFFF, b=0x80000000 (overflow case) → result 0, zero 1.
- a=0xF0F0F0F0, b=0xFF00FF00: AND → 0xF000F000, OR → 0xFFF0FFF0, XOR → 0x0FF00FF0; alu_ctrl=3'b111 → ADD result 0xEFF1EFF0.
- Backpressure: out_ready low 5 cycles in DONE → result stable, in_ready 0, a concurrent in_valid is not accepted; out_ready high → IDLE next cycle, then the new request is accepted.
- Reset pulse at RUN cycle 3 → out_valid never asserts for that op, in_ready 1 the cycle after rst drops, and the next ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and FSM state type for the serial ALU and the
// ALU control decoder.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // SUB and SLT both compute a + ~b + 1
  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational SLICE-bit datapath: one slice of add/sub/logic per cycle.
module serial_alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] res,
  output logic             cout
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum;

  // Adder shared by ADD/SUB/SLT; logic ops bypass it and drive cout low
  always_comb begin
    b_eff = op_is_sub(op) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
    res   = sum[SLICE-1:0];
    cout  = sum[SLICE];
    case (op)
      ALU_AND: begin res = a & b; cout = 1'b0; end
      ALU_OR:  begin res = a | b; cout = 1'b0; end
      ALU_XOR: begin res = a ^ b; cout = 1'b0; end
      default: ; // ADD, SUB, SLT and the unused codes 110/111 (run as ADD)
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Slice-serial ALU: accepts one request, processes SLICE bits per cycle for
// XLEN/SLICE cycles, then presents result and zero flag until consumed.
module serial_alu
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SLICE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int N  = XLEN / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t               state;
  logic [2:0]           ctrl;
  logic [XLEN-1:0]      a_sh, b_sh;
  // Holds the slices already produced; the final slice is merged on the last edge
  logic [XLEN-SLICE-1:0] res_sh;
  logic [CW-1:0]        cnt;
  logic                 carry;
  logic                 zacc;

  logic [SLICE-1:0]     s_res;
  logic                 s_cout;
  logic                 a_msb, b_msb, sum_msb, ovf, less;

  serial_alu_slice #(.SLICE(SLICE)) u_slice (
    .op   (ctrl),
    .a    (a_sh[SLICE-1:0]),
    .b    (b_sh[SLICE-1:0]),
    .cin  (carry),
    .res  (s_res),
    .cout (s_cout)
  );

  assign in_ready = (state == ST_IDLE) && !rst;

  // Signed less-than from the top slice of a - b (only meaningful on the last slice)
  always_comb begin
    a_msb   = a_sh[SLICE-1];
    b_msb   = b_sh[SLICE-1];
    sum_msb = s_res[SLICE-1];
    ovf     = (a_msb != b_msb) && (sum_msb != a_msb);
    less    = sum_msb ^ ovf;
  end

  // Control FSM plus operand/result shift registers, carry and zero tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ctrl      <= ALU_ADD;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      zacc      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            ctrl  <= alu_ctrl;
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= '0;
            carry <= op_is_sub(alu_ctrl);
            zacc  <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> SLICE;
          b_sh   <= b_sh >> SLICE;
          res_sh <= {s_res, res_sh[XLEN-SLICE-1:SLICE]};
          carry  <= s_cout;
          zacc   <= zacc | (|s_res);
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            if (ctrl == ALU_SLT) begin
              result <= {{(XLEN-1){1'b0}}, less};
              zero   <= !less;
            end else begin
              result <= {s_res, res_sh};
              zero   <= !(zacc | (|s_res));
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: hand-computed vectors, latency, backpressure
// and mid-operation reset.
module tb_serial_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int n_chk = 0;
  int n_err = 0;

  serial_alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait for out_valid after an accept edge; returns cycles counted (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] er, input logic ez);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    alu_ctrl = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the unit must ignore them after acceptance
    in_valid = 1'b0; a = ~av; b = ~bv; alu_ctrl = ~op;
    wait_done(lat);
    chk({tag, ".lat"}, 32'(lat), 32'd8);
    chk({tag, ".result"}, result, er);
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".ov_clr"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = 3'b000; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.zero", 32'(zero), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready_after", 32'(in_ready), 32'd1);

    do_op("add_ovf",  3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
    do_op("sub_eq",   3'b001, 32'd5,        32'd5,        32'h00000000, 1'b1);
    do_op("sub_neg",  3'b001, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0);
    do_op("slt_neg",  3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    do_op("slt_ovf",  3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1);
    do_op("and",      3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    do_op("or",       3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
    do_op("xor",      3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
    do_op("ctrl111",  3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hEFF1EFF0, 1'b0);
    do_op("xor_zero", 3'b100, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1);

    // Backpressure: hold DONE, offer a competing request, then release
    @(negedge clk);
    alu_ctrl = 3'b000; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp.lat", 32'(lat), 32'd8);
    @(negedge clk);
    a = 32'd10; b = 32'd20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.result", result, 32'd3);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_ov", 32'(out_valid), 32'd0);
    chk("bp.release_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp.next_lat", 32'(lat), 32'd8);
    chk("bp.next_result", result, 32'd30);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset during RUN abandons the operation
    @(negedge clk);
    alu_ctrl = 3'b000; a = 32'd100; b = 32'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst.in_ready_after", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst.no_result", 32'(seen), 32'd0);
    do_op("post_rst_add", 3'b000, 32'd2, 32'd3, 32'd5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
